// File: rtl/nic_vc_allocator.sv
// Virtual-channel allocator: grants idle NoC VCs to NIC output buffers with a packet head ready.
// One grant per virtual network per cycle; round-robin over requesters, lowest free VC first.
module nic_vc_allocator #(
    parameter int unsigned N_OF_VN        = 2,
    parameter int unsigned N_OF_VC        = 3,
    parameter int unsigned N_TOT_OF_VC    = N_OF_VC * N_OF_VN,
    parameter int unsigned N_FIFO_BUFFER  = 16,
    parameter int unsigned N_BITS_POINTER = $clog2(N_FIFO_BUFFER),
    parameter int unsigned N_BITS_VN      = (N_OF_VN > 1) ? $clog2(N_OF_VN) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_FIFO_BUFFER-1:0]                req_i,
    input  logic [N_FIFO_BUFFER*N_BITS_VN-1:0]      req_vn_i,
    input  logic [N_TOT_OF_VC-1:0]                  fifo_pointer_state_i,
    output logic [N_TOT_OF_VC-1:0]                  g_fifo_pointer_o,
    output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0]   g_fifo_out_buffer_id_o,
    output logic [N_FIFO_BUFFER-1:0]                gnt_o,
    output logic [N_FIFO_BUFFER*N_BITS_POINTER-1:0] gnt_vc_o
);

    logic [N_BITS_POINTER-1:0] rr_q [N_OF_VN];
    logic [N_BITS_POINTER-1:0] rr_d [N_OF_VN];

    logic [N_TOT_OF_VC-1:0]                  busy;
    logic [N_FIFO_BUFFER-1:0]                eff_req;
    logic [N_TOT_OF_VC-1:0]                  gptr_d;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0]   id_d;
    logic [N_FIFO_BUFFER-1:0]                gnt_d;
    logic [N_FIFO_BUFFER*N_BITS_POINTER-1:0] gvc_d;

    logic                      found_req;
    logic [N_BITS_POINTER-1:0] winner;
    logic [N_BITS_POINTER-1:0] idx;
    logic [N_TOT_OF_VC-1:0]    vc_oh;
    logic [N_BITS_POINTER-1:0] vc_sel;

    always_comb begin
        // Last cycle's grants are not yet visible in the pointer table state.
        busy      = fifo_pointer_state_i | g_fifo_pointer_o;
        eff_req   = req_i & ~gnt_o;
        gptr_d    = '0;
        id_d      = '0;
        gnt_d     = '0;
        gvc_d     = '0;
        rr_d      = rr_q;
        found_req = 1'b0;
        winner    = '0;
        idx       = '0;
        vc_oh     = '0;
        vc_sel    = '0;

        for (int unsigned v = 0; v < N_OF_VN; v++) begin
            found_req = 1'b0;
            winner    = '0;
            for (int unsigned off = 0; off < N_FIFO_BUFFER; off++) begin
                idx = N_BITS_POINTER'((32'(rr_q[v]) + off) % N_FIFO_BUFFER);
                if (!found_req && eff_req[idx]
                    && 32'(req_vn_i[idx*N_BITS_VN +: N_BITS_VN]) == v) begin
                    found_req = 1'b1;
                    winner    = idx;
                end
            end

            // Scan downward so the last hit is the lowest-index free VC.
            vc_oh  = '0;
            vc_sel = '0;
            for (int c = int'(N_OF_VC) - 1; c >= 0; c--) begin
                if (!busy[v*N_OF_VC + c]) begin
                    vc_oh                   = '0;
                    vc_oh[v*N_OF_VC + c]    = 1'b1;
                    vc_sel                  = N_BITS_POINTER'(v*N_OF_VC + c);
                end
            end

            if (found_req && (|vc_oh)) begin
                gptr_d = gptr_d | vc_oh;
                for (int unsigned k = 0; k < N_TOT_OF_VC; k++) begin
                    if (vc_oh[k]) begin
                        id_d[k*N_BITS_POINTER +: N_BITS_POINTER] = winner;
                    end
                end
                gnt_d[winner]                                   = 1'b1;
                gvc_d[winner*N_BITS_POINTER +: N_BITS_POINTER]  = vc_sel;
                rr_d[v] = (32'(winner) == N_FIFO_BUFFER - 1) ? '0 : winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g_fifo_pointer_o       <= '0;
            g_fifo_out_buffer_id_o <= '0;
            gnt_o                  <= '0;
            gnt_vc_o               <= '0;
            for (int unsigned v = 0; v < N_OF_VN; v++) begin
                rr_q[v] <= '0;
            end
        end else begin
            g_fifo_pointer_o       <= gptr_d;
            g_fifo_out_buffer_id_o <= id_d;
            gnt_o                  <= gnt_d;
            gnt_vc_o               <= gvc_d;
            for (int unsigned v = 0; v < N_OF_VN; v++) begin
                rr_q[v] <= rr_d[v];
            end
        end
    end

endmodule

// File: tb/tb_nic_vc_allocator.sv
// Self-checking bench for nic_vc_allocator: directed scenarios plus random traffic
// compared cycle by cycle against a distance-based round-robin reference model.
module tb_nic_vc_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_i;
    logic [15:0] req_vn_i;
    logic [5:0]  fifo_pointer_state_i;
    logic [5:0]  g_fifo_pointer_o;
    logic [23:0] g_fifo_out_buffer_id_o;
    logic [15:0] gnt_o;
    logic [63:0] gnt_vc_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state: previous registered outputs and per-VN pointers.
    int          m_rr [2];
    int          nxt_rr [2];
    logic [5:0]  m_gptr;
    logic [15:0] m_gnt;
    logic [5:0]  exp_gptr;
    logic [23:0] exp_id;
    logic [15:0] exp_gnt;
    logic [63:0] exp_gvc;

    nic_vc_allocator dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_i                  (req_i),
        .req_vn_i               (req_vn_i),
        .fifo_pointer_state_i   (fifo_pointer_state_i),
        .g_fifo_pointer_o       (g_fifo_pointer_o),
        .g_fifo_out_buffer_id_o (g_fifo_out_buffer_id_o),
        .gnt_o                  (gnt_o),
        .gnt_vc_o               (gnt_vc_o)
    );

    always #5 clk = ~clk;

    // Pick, per VN, the eligible requester with the smallest upward distance from the pointer.
    task automatic model_eval();
        int best, bestd, vc, d;
        logic [3:0] b4;
        logic [3:0] v4;
        exp_gptr = '0;
        exp_id   = '0;
        exp_gnt  = '0;
        exp_gvc  = '0;
        nxt_rr   = m_rr;
        for (int v = 0; v < 2; v++) begin
            best  = -1;
            bestd = 16;
            for (int i = 0; i < 16; i++) begin
                if (req_i[i] && !m_gnt[i] && int'(req_vn_i[i]) == v) begin
                    d = (i - m_rr[v] + 16) % 16;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
            vc = -1;
            for (int c = 2; c >= 0; c--) begin
                if (!fifo_pointer_state_i[v*3+c] && !m_gptr[v*3+c]) vc = v*3 + c;
            end
            if (best >= 0 && vc >= 0) begin
                b4 = 4'(best);
                v4 = 4'(vc);
                exp_gnt[best]       = 1'b1;
                exp_gptr[vc]        = 1'b1;
                exp_id[vc*4 +: 4]   = b4;
                exp_gvc[best*4 +: 4] = v4;
                nxt_rr[v]           = (best + 1) % 16;
            end
        end
        if (rst) begin
            exp_gptr = '0;
            exp_id   = '0;
            exp_gnt  = '0;
            exp_gvc  = '0;
            nxt_rr   = '{0, 0};
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        m_gptr = exp_gptr;
        m_gnt  = exp_gnt;
        m_rr   = nxt_rr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_i = 16'hFFFF;
        req_vn_i = 16'hAAAA;
        fifo_pointer_state_i = '0;
        repeat (2) cycle();
        checks++;
        if ({gnt_o, g_fifo_pointer_o, g_fifo_out_buffer_id_o, gnt_vc_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%h ptr=%b id=%h vc=%h, want all 0",
                     gnt_o, g_fifo_pointer_o, g_fifo_out_buffer_id_o, gnt_vc_o);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (gnt_o !== 16'h0003) begin
            failures++;
            $display("FAIL reset_first_gnt: got %h want 0003", gnt_o);
        end
        checks++;
        if (g_fifo_pointer_o !== 6'b001001) begin
            failures++;
            $display("FAIL reset_first_ptr: got %b want 001001", g_fifo_pointer_o);
        end
        checks++;
        if (g_fifo_out_buffer_id_o[3:0] !== 4'd0 || g_fifo_out_buffer_id_o[15:12] !== 4'd1) begin
            failures++;
            $display("FAIL reset_first_ids: got id0=%0d id3=%0d want 0 and 1",
                     g_fifo_out_buffer_id_o[3:0], g_fifo_out_buffer_id_o[15:12]);
        end
        checks++;
        if (gnt_vc_o !== exp_gvc) begin
            failures++;
            $display("FAIL reset_first_vc: got %h want %h", gnt_vc_o, exp_gvc);
        end
        req_i = '0;
        repeat (2) cycle();
    endtask

    task automatic test_round_robin();
        int wins [4] = '{2, 5, 9, 2};
        int vcs  [4] = '{0, 1, 0, 1};
        req_vn_i = '0;
        fifo_pointer_state_i = '0;
        for (int n = 0; n < 4; n++) begin
            req_i = 16'h0224 & ~gnt_o;
            cycle();
            checks++;
            if (gnt_o !== (16'h1 << wins[n]) || g_fifo_pointer_o !== (6'h1 << vcs[n])) begin
                failures++;
                $display("FAIL rr_rotate[%0d]: got gnt=%h ptr=%b want buffer %0d vc %0d",
                         n, gnt_o, g_fifo_pointer_o, wins[n], vcs[n]);
            end
            checks++;
            if ({g_fifo_out_buffer_id_o, gnt_vc_o} !== {exp_id, exp_gvc}) begin
                failures++;
                $display("FAIL rr_fields[%0d]: got id=%h vc=%h want id=%h vc=%h",
                         n, g_fifo_out_buffer_id_o, gnt_vc_o, exp_id, exp_gvc);
            end
        end
        req_i = '0;
        cycle();
    endtask

    task automatic test_all_busy();
        fifo_pointer_state_i = 6'b000111;
        req_i = 16'h0010;
        repeat (2) begin
            cycle();
            checks++;
            if (gnt_o !== '0 || g_fifo_pointer_o !== '0) begin
                failures++;
                $display("FAIL busy_wait: got gnt=%h ptr=%b want 0", gnt_o, g_fifo_pointer_o);
            end
        end
        fifo_pointer_state_i = 6'b000101;
        cycle();
        checks++;
        if (g_fifo_pointer_o !== 6'b000010 || gnt_o !== 16'h0010) begin
            failures++;
            $display("FAIL busy_release: got ptr=%b gnt=%h want 000010 0010",
                     g_fifo_pointer_o, gnt_o);
        end
        checks++;
        if (g_fifo_out_buffer_id_o[7:4] !== 4'd4 || gnt_vc_o[19:16] !== 4'd1) begin
            failures++;
            $display("FAIL busy_fields: got id1=%0d vc4=%0d want 4 1",
                     g_fifo_out_buffer_id_o[7:4], gnt_vc_o[19:16]);
        end
        req_i = '0;
        fifo_pointer_state_i = '0;
        cycle();
    endtask

    task automatic test_dual_vn();
        req_i = 16'h0088;
        req_vn_i = 16'h0080;
        cycle();
        checks++;
        if (gnt_o !== 16'h0088 || g_fifo_pointer_o !== 6'b001001) begin
            failures++;
            $display("FAIL dual_vn: got gnt=%h ptr=%b want 0088 001001", gnt_o, g_fifo_pointer_o);
        end
        checks++;
        if (g_fifo_out_buffer_id_o[3:0] !== 4'd3 || g_fifo_out_buffer_id_o[15:12] !== 4'd7) begin
            failures++;
            $display("FAIL dual_vn_ids: got id0=%0d id3=%0d want 3 7",
                     g_fifo_out_buffer_id_o[3:0], g_fifo_out_buffer_id_o[15:12]);
        end
        req_i = '0;
        req_vn_i = '0;
        cycle();
    endtask

    task automatic test_back_to_back();
        req_i = 16'h0010;
        cycle();
        req_i = 16'h0020;
        cycle();
        checks++;
        if (g_fifo_pointer_o !== 6'b000010 || gnt_o !== 16'h0020) begin
            failures++;
            $display("FAIL back_to_back: got ptr=%b gnt=%h want 000010 0020",
                     g_fifo_pointer_o, gnt_o);
        end
        req_i = '0;
        cycle();
    endtask

    task automatic test_reset_mid();
        req_i = 16'h0040;
        req_vn_i = 16'h0040;
        rst = 1'b1;
        cycle();
        checks++;
        if ({gnt_o, g_fifo_pointer_o, g_fifo_out_buffer_id_o, gnt_vc_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got gnt=%h ptr=%b want 0", gnt_o, g_fifo_pointer_o);
        end
        rst = 1'b0;
        req_i = '0;
        cycle();
        req_i = 16'h4406;
        req_vn_i = 16'h0402;
        cycle();
        checks++;
        if (gnt_o !== 16'h0006) begin
            failures++;
            $display("FAIL reset_rr_cleared: got gnt=%h want 0006", gnt_o);
        end
        req_i = '0;
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            req_i = 16'($urandom) & 16'($urandom);
            req_vn_i = 16'($urandom);
            fifo_pointer_state_i = 6'($urandom) & 6'($urandom);
            cycle();
            checks++;
            if ({gnt_o, g_fifo_pointer_o, g_fifo_out_buffer_id_o, gnt_vc_o}
                !== {exp_gnt, exp_gptr, exp_id, exp_gvc}) begin
                failures++;
                $display("FAIL random[%0d]: got gnt=%h ptr=%b id=%h vc=%h want gnt=%h ptr=%b id=%h vc=%h",
                         n, gnt_o, g_fifo_pointer_o, g_fifo_out_buffer_id_o, gnt_vc_o,
                         exp_gnt, exp_gptr, exp_id, exp_gvc);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_rr   = '{0, 0};
        m_gptr = '0;
        m_gnt  = '0;
        rst = 1'b1;
        req_i = '0;
        req_vn_i = '0;
        fifo_pointer_state_i = '0;
        test_reset();
        test_round_robin();
        test_all_busy();
        test_dual_vn();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nic_vc_allocator.md
Name: nic_vc_allocator

Overview:
- Allocates idle NoC virtual channels to NIC output FIFO buffers that have a packet head ready.
- Sits between the wishbone-slave output buffers (requesters) and the NIC-to-NoC pointer table.
- Drives the pointer table's grant vector and buffer-id bus, and reads back its per-VC busy state.
- Per virtual network, at most one grant per cycle; requesters are served round-robin and idle VCs lowest-index-first.

Parameters:
- N_OF_VN, 2, number of virtual networks.
- N_OF_VC, 3, VCs per virtual network.
- N_TOT_OF_VC, 6, N_OF_VC*N_OF_VN.
- N_FIFO_BUFFER, 16, number of requesting output buffers.
- N_BITS_POINTER, 4, clog2(N_FIFO_BUFFER).
- N_BITS_VN, 1, clog2(N_OF_VN), minimum 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- req_i  input  N_FIFO_BUFFER  buffer i requests a VC.
- req_vn_i  input  N_FIFO_BUFFER*N_BITS_VN  VN of buffer i's request, field i.
- fifo_pointer_state_i  input  N_TOT_OF_VC  1 = VC busy, 0 = idle; from the pointer table.
- g_fifo_pointer_o  output  N_TOT_OF_VC  VC k allocated this cycle; one-cycle pulse.
- g_fifo_out_buffer_id_o  output  N_TOT_OF_VC*N_BITS_POINTER  field k = buffer id granted VC k.
- gnt_o  output  N_FIFO_BUFFER  buffer i granted; one-cycle pulse.
- gnt_vc_o  output  N_FIFO_BUFFER*N_BITS_POINTER  field i = global VC index granted to buffer i; valid only with gnt_o[i].

Behaviour:
- All outputs are registered. Reset clears all outputs and sets every per-VN round-robin pointer to 0. Reset mid-operation drops any grant computed in that cycle.
- VC k belongs to VN k/N_OF_VC.
- Effective busy mask = fifo_pointer_state_i | g_fifo_pointer_o. This covers the one cycle before the pointer table shows the grant as busy.
- Effective request of buffer i = req_i[i] & ~gnt_o[i]. A buffer granted in the previous cycle is ignored for one cycle. The requester must drop req_i on the cycle after its gnt_o pulse.
- Per VN v, each cycle (combinational, registered at the edge):
  - Eligible requesters: effective request with req_vn_i == v.
  - Free VCs: VCs of VN v with effective busy = 0.
  - If both sets are non-empty, the winner is the first eligible requester at or after rr_ptr[v], scanning upward with wrap at N_FIFO_BUFFER-1 -> 0.
  - The VC chosen is the lowest-index free VC of VN v.
- Grant registration (latency 1 cycle from request to grant):
  - g_fifo_pointer_o[vc] = 1.
  - id field[vc] = winner.
  - gnt_o[winner] = 1.
  - gnt_vc_o[winner] = vc.
  - rr_ptr[v] <= winner+1, wrapping N_FIFO_BUFFER-1 -> 0.
- If no grant is made, rr_ptr[v] holds, and all id/vc fields read 0.
- VNs are independent: up to N_OF_VN grants in the same cycle, to different buffers and different VCs.
- Requests with req_vn_i >= N_OF_VN are ignored and never granted.
- All VCs of a VN busy: its requesters wait with no grant and no pointer change.
- A VC released (state falls) and requested in the same cycle is grantable that cycle.

Test Plan:
- Reset with req_i = all ones, all VCs idle -> all outputs 0 during reset. First cycle after reset: gnt_o[0] = 1 and gnt_o bit of the first VN1 requester = 1; g_fifo_pointer_o = 6'b001001; id fields 0 and the VN1 winner.
- Buffers 2, 5, 9 request VN0 continuously (each dropping for one cycle after its grant), state held idle via release -> grants rotate 2, 5, 9, 2. VCs used: 0, then 1 (VC0 masked), then 0 or 2 depending on the state fed back.
- fifo_pointer_state_i = 6'b000111, buffer 4 requests VN0 -> no grant. Clear bit 1 -> next cycle g_fifo_pointer_o = 6'b000010, id field 1 = 4, gnt_vc_o field 4 = 1.
- Buffer 3 on VN0 and buffer 7 on VN1, both in the same cycle, all idle -> same-cycle grants: VC0 to buffer 3, VC3 to buffer 7.
- Grant issued, state input not yet busy next cycle, a new VN0 request arrives -> the just-granted VC is not reissued; the next free VC is given.
- rst asserted in the cycle a grant is being computed -> no grant appears; rr pointers are 0 after reset.
